// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the hardwired control sequencer: opcodes, ALU codes,
// datapath strobe bit positions, state encoding and the decoded-instruction payload.
package cpu_ctrl_pkg;

    localparam int unsigned OPC_W   = 5;
    localparam int unsigned ALU_W   = 5;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned WORD_W  = 32;

    localparam logic [OPC_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OPC_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPC_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_AND  = 5'b01001;
    localparam logic [OPC_W-1:0] OP_OR   = 5'b01010;
    localparam logic [OPC_W-1:0] OP_ADDI = 5'b01011;
    localparam logic [OPC_W-1:0] OP_ANDI = 5'b01100;
    localparam logic [OPC_W-1:0] OP_ORI  = 5'b01101;
    localparam logic [OPC_W-1:0] OP_BR   = 5'b10011;
    localparam logic [OPC_W-1:0] OP_JR   = 5'b10100;
    localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

    localparam logic [ALU_W-1:0] ALU_NONE  = 5'd0;
    localparam logic [ALU_W-1:0] ALU_ADD   = 5'd1;
    localparam logic [ALU_W-1:0] ALU_SUB   = 5'd2;
    localparam logic [ALU_W-1:0] ALU_AND   = 5'd3;
    localparam logic [ALU_W-1:0] ALU_OR    = 5'd4;
    localparam logic [ALU_W-1:0] ALU_INCPC = 5'd14;

    // Bit positions within the datapath enable vector
    localparam logic [4:0] EN_ZIN   = 5'd18;
    localparam logic [4:0] EN_YIN   = 5'd19;
    localparam logic [4:0] EN_PCIN  = 5'd20;
    localparam logic [4:0] EN_MDRIN = 5'd21;
    localparam logic [4:0] EN_IRIN  = 5'd24;
    localparam logic [4:0] EN_MARIN = 5'd25;
    localparam logic [4:0] EN_CONIN = 5'd27;

    // Bit positions within the one-hot bus source select
    localparam logic [4:0] BS_ZLO = 5'd19;
    localparam logic [4:0] BS_PC  = 5'd20;
    localparam logic [4:0] BS_MDR = 5'd21;
    localparam logic [4:0] BS_C   = 5'd23;

    localparam logic [STATE_W-1:0] S_RESET  = 4'd0;
    localparam logic [STATE_W-1:0] S_T0     = 4'd1;
    localparam logic [STATE_W-1:0] S_T1     = 4'd2;
    localparam logic [STATE_W-1:0] S_T2     = 4'd3;
    localparam logic [STATE_W-1:0] S_T3     = 4'd4;
    localparam logic [STATE_W-1:0] S_T4     = 4'd5;
    localparam logic [STATE_W-1:0] S_T5     = 4'd6;
    localparam logic [STATE_W-1:0] S_T6     = 4'd7;
    localparam logic [STATE_W-1:0] S_T7     = 4'd8;
    localparam logic [STATE_W-1:0] S_HALTED = 4'd9;

    typedef enum logic [3:0] {
        CLS_ALU_R,
        CLS_ALU_I,
        CLS_LDI,
        CLS_LD,
        CLS_ST,
        CLS_BR,
        CLS_JR,
        CLS_NOP,
        CLS_HALT
    } instr_class_e;

    typedef struct packed {
        instr_class_e     cls;
        logic [ALU_W-1:0] alu_op;
    } decode_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decode: instruction class plus the ALU operation used
// by its execute steps (address and branch-target arithmetic use ADD).
module ctrl_decode
    import cpu_ctrl_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic [OPC_W-1:0] opcode,
    output decode_t          dec_c
);

    always_comb begin
        dec_c.cls    = HALT_ON_ILLEGAL ? CLS_HALT : CLS_NOP;
        dec_c.alu_op = ALU_NONE;
        case (opcode)
            OP_ADD:  begin dec_c.cls = CLS_ALU_R; dec_c.alu_op = ALU_ADD; end
            OP_SUB:  begin dec_c.cls = CLS_ALU_R; dec_c.alu_op = ALU_SUB; end
            OP_AND:  begin dec_c.cls = CLS_ALU_R; dec_c.alu_op = ALU_AND; end
            OP_OR:   begin dec_c.cls = CLS_ALU_R; dec_c.alu_op = ALU_OR;  end
            OP_ADDI: begin dec_c.cls = CLS_ALU_I; dec_c.alu_op = ALU_ADD; end
            OP_ANDI: begin dec_c.cls = CLS_ALU_I; dec_c.alu_op = ALU_AND; end
            OP_ORI:  begin dec_c.cls = CLS_ALU_I; dec_c.alu_op = ALU_OR;  end
            OP_LDI:  begin dec_c.cls = CLS_LDI;   dec_c.alu_op = ALU_ADD; end
            OP_LD:   begin dec_c.cls = CLS_LD;    dec_c.alu_op = ALU_ADD; end
            OP_ST:   begin dec_c.cls = CLS_ST;    dec_c.alu_op = ALU_ADD; end
            OP_BR:   begin dec_c.cls = CLS_BR;    dec_c.alu_op = ALU_ADD; end
            OP_JR:   dec_c.cls = CLS_JR;
            OP_NOP:  dec_c.cls = CLS_NOP;
            OP_HALT: dec_c.cls = CLS_HALT;
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: steps the datapath through fetch (T0-T2) and the
// per-opcode execute steps, with Moore strobes decoded from the current state.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [WORD_W-1:0] ir,
    input  logic              CONFFOut,
    output logic [WORD_W-1:0] enable,
    output logic [WORD_W-1:0] busSelect,
    output logic [ALU_W-1:0]  Control_Signals,
    output logic              MD_Read,
    output logic              ReadRAM,
    output logic              WriteRAM,
    output logic              Gra,
    output logic              Grb,
    output logic              Grc,
    output logic              Rin,
    output logic              Rout,
    output logic              BAout,
    output logic              run
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] next_state;
    logic [OPC_W-1:0]   opcode_c;
    decode_t            dec_c;
    logic               ir_unused_c;

    assign opcode_c = ir[31:27];
    // Register-field and constant bits are consumed by the datapath's select-and-encode
    assign ir_unused_c = ^ir[26:0];

    ctrl_decode #(
        .HALT_ON_ILLEGAL (HALT_ON_ILLEGAL)
    ) u_decode (
        .opcode (opcode_c),
        .dec_c  (dec_c)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= S_RESET;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_RESET: next_state = S_T0;
            S_T0:    next_state = S_T1;
            S_T1:    next_state = S_T2;
            S_T2:    next_state = S_T3;
            S_T3: begin
                if (dec_c.cls == CLS_HALT) begin
                    next_state = S_HALTED;
                end else if (dec_c.cls inside {CLS_JR, CLS_NOP}) begin
                    next_state = S_T0;
                end else begin
                    next_state = S_T4;
                end
            end
            S_T4:    next_state = S_T5;
            S_T5:    next_state = (dec_c.cls inside {CLS_LD, CLS_ST, CLS_BR}) ? S_T6 : S_T0;
            S_T6:    next_state = (dec_c.cls inside {CLS_LD, CLS_ST}) ? S_T7 : S_T0;
            S_T7:    next_state = S_T0;
            S_HALTED: next_state = S_HALTED;
            default: next_state = S_RESET;
        endcase
    end

    // Strobe decode; RESET, HALTED and unused encodings leave everything low
    always_comb begin
        enable          = '0;
        busSelect       = '0;
        Control_Signals = ALU_NONE;
        MD_Read         = 1'b0;
        ReadRAM         = 1'b0;
        WriteRAM        = 1'b0;
        Gra             = 1'b0;
        Grb             = 1'b0;
        Grc             = 1'b0;
        Rin             = 1'b0;
        Rout            = 1'b0;
        BAout           = 1'b0;
        run             = 1'b1;
        case (state)
            S_T0: begin
                busSelect[BS_PC]  = 1'b1;
                enable[EN_MARIN]  = 1'b1;
                Control_Signals   = ALU_INCPC;
                enable[EN_ZIN]    = 1'b1;
            end
            S_T1: begin
                busSelect[BS_ZLO] = 1'b1;
                enable[EN_PCIN]   = 1'b1;
                ReadRAM           = 1'b1;
                MD_Read           = 1'b1;
                enable[EN_MDRIN]  = 1'b1;
            end
            S_T2: begin
                busSelect[BS_MDR] = 1'b1;
                enable[EN_IRIN]   = 1'b1;
            end
            S_T3: begin
                case (dec_c.cls)
                    CLS_ALU_R, CLS_ALU_I: begin
                        Grb = 1'b1; Rout = 1'b1; enable[EN_YIN] = 1'b1;
                    end
                    CLS_LDI, CLS_LD, CLS_ST: begin
                        Grb = 1'b1; BAout = 1'b1; enable[EN_YIN] = 1'b1;
                    end
                    CLS_BR: begin
                        Gra = 1'b1; Rout = 1'b1; enable[EN_CONIN] = 1'b1;
                    end
                    CLS_JR: begin
                        Gra = 1'b1; Rout = 1'b1; enable[EN_PCIN] = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                case (dec_c.cls)
                    CLS_ALU_R: begin
                        Grc = 1'b1; Rout = 1'b1;
                        Control_Signals = dec_c.alu_op; enable[EN_ZIN] = 1'b1;
                    end
                    CLS_ALU_I, CLS_LDI, CLS_LD, CLS_ST: begin
                        busSelect[BS_C] = 1'b1;
                        Control_Signals = dec_c.alu_op; enable[EN_ZIN] = 1'b1;
                    end
                    CLS_BR: begin
                        busSelect[BS_PC] = 1'b1; enable[EN_YIN] = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (dec_c.cls)
                    CLS_ALU_R, CLS_ALU_I, CLS_LDI: begin
                        busSelect[BS_ZLO] = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    CLS_LD, CLS_ST: begin
                        busSelect[BS_ZLO] = 1'b1; enable[EN_MARIN] = 1'b1;
                    end
                    CLS_BR: begin
                        busSelect[BS_C] = 1'b1;
                        Control_Signals = dec_c.alu_op; enable[EN_ZIN] = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (dec_c.cls)
                    CLS_LD: begin
                        ReadRAM = 1'b1; MD_Read = 1'b1; enable[EN_MDRIN] = 1'b1;
                    end
                    CLS_ST: begin
                        Gra = 1'b1; Rout = 1'b1; enable[EN_MDRIN] = 1'b1;
                    end
                    CLS_BR: begin
                        // Target is always on the bus; the condition only gates the PC load
                        busSelect[BS_ZLO] = 1'b1; enable[EN_PCIN] = CONFFOut;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (dec_c.cls)
                    CLS_LD: begin
                        busSelect[BS_MDR] = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    CLS_ST:  WriteRAM = 1'b1;
                    default: ;
                endcase
            end
            default: run = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: drives a small behavioural datapath
// model from the sequencer strobes and checks strobes per step and architectural results.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [31:0] irm = '0;
    logic        con = 1'b0;
    logic [31:0] enable, busSelect;
    logic [4:0]  Control_Signals;
    logic        MD_Read, ReadRAM, WriteRAM, Gra, Grb, Grc, Rin, Rout, BAout, run;

    control_sequencer #(.HALT_ON_ILLEGAL(1'b0)) dut (
        .clk(clk), .clr(clr), .ir(irm), .CONFFOut(con),
        .enable(enable), .busSelect(busSelect), .Control_Signals(Control_Signals),
        .MD_Read(MD_Read), .ReadRAM(ReadRAM), .WriteRAM(WriteRAM),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .run(run)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    localparam logic [31:0] ZIN = 32'h0004_0000, YIN = 32'h0008_0000, PCIN = 32'h0010_0000;
    localparam logic [31:0] MDRIN = 32'h0020_0000, IRIN = 32'h0100_0000, MARIN = 32'h0200_0000;
    localparam logic [31:0] CONIN = 32'h0800_0000;
    localparam logic [31:0] ZLO = 32'h0008_0000, PCO = 32'h0010_0000, MDRO = 32'h0020_0000;
    localparam logic [31:0] COUT = 32'h0080_0000;
    localparam logic [8:0] F_MDRD = 9'h100, F_RRD = 9'h080, F_WR = 9'h040, F_GRA = 9'h020;
    localparam logic [8:0] F_GRB = 9'h010, F_GRC = 9'h008, F_RIN = 9'h004, F_ROUT = 9'h002;
    localparam logic [8:0] F_BA = 9'h001;

    // Datapath model state; written only by the posedge process
    logic [31:0] rf [16];
    logic [31:0] mem [512];
    logic [31:0] pc, mar, mdr, y, z;
    // Program and initial register image loaded into the model while clr is high
    logic [31:0] prog_rf [16];
    logic [31:0] prog_mem [512];
    // Strobes and bus value captured mid-cycle, applied at the next posedge
    logic [31:0] s_en, bus_s;
    logic [4:0]  s_alu;
    logic        s_mdrd, s_wr, s_rin;
    logic [3:0]  s_sel;

    function automatic logic [78:0] obs();
        return {enable, busSelect, Control_Signals, MD_Read, ReadRAM, WriteRAM,
                Gra, Grb, Grc, Rin, Rout, BAout, run};
    endfunction

    function automatic logic [78:0] xp(input logic [31:0] en, input logic [31:0] bs,
                                       input logic [4:0] alu, input logic [8:0] fl,
                                       input logic rn);
        return {en, bs, alu, fl, rn};
    endfunction

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] a,
                                        input logic [3:0] b, input logic [3:0] c,
                                        input logic [18:0] k);
        return {op, a, b, k | {c, 15'b0}};
    endfunction

    always @(negedge clk) begin
        logic [3:0] sel;
        logic [31:0] b;
        sel = Gra ? irm[26:23] : Grb ? irm[22:19] : Grc ? irm[18:15] : 4'd0;
        b = '0;
        if (busSelect[20]) b = pc;
        if (busSelect[19]) b = z;
        if (busSelect[21]) b = mdr;
        if (busSelect[23]) b = {{13{irm[18]}}, irm[18:0]};
        if (Rout) b = rf[sel];
        if (BAout) b = (sel == 4'd0) ? 32'd0 : rf[sel];
        bus_s  = b;
        s_sel  = sel;
        s_en   = enable;
        s_alu  = Control_Signals;
        s_mdrd = MD_Read;
        s_wr   = WriteRAM;
        s_rin  = Rin;
    end

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 16; i++) rf[i] = prog_rf[i];
            for (int i = 0; i < 512; i++) mem[i] = prog_mem[i];
            pc = '0; mar = '0; mdr = '0; y = '0; z = '0; irm = '0; con = 1'b0;
        end else begin
            if (s_en[18]) begin
                case (s_alu)
                    5'd1:    z = y + bus_s;
                    5'd2:    z = y - bus_s;
                    5'd3:    z = y & bus_s;
                    5'd4:    z = y | bus_s;
                    5'd14:   z = bus_s + 32'd1;
                    default: z = '0;
                endcase
            end
            if (s_en[19]) y = bus_s;
            if (s_en[20]) pc = bus_s;
            if (s_en[21]) mdr = s_mdrd ? mem[mar[8:0]] : bus_s;
            if (s_en[24]) irm = bus_s;
            if (s_en[25]) mar = bus_s;
            if (s_en[27]) begin
                case (irm[20:19])
                    2'b00: con = (bus_s == 32'd0);
                    2'b01: con = (bus_s != 32'd0);
                    2'b10: con = ~bus_s[31];
                    2'b11: con = bus_s[31];
                endcase
            end
            if (s_rin) rf[s_sel] = bus_s;
            if (s_wr) mem[mar[8:0]] = mdr;
        end
    end

    task automatic load_begin();
        clr = 1'b1;
        for (int i = 0; i < 16; i++) prog_rf[i] = '0;
        for (int i = 0; i < 512; i++) prog_mem[i] = '0;
    endtask

    task automatic release_clr();
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        load_begin();
        @(negedge clk);
        vectors++;
        if (obs() !== 79'd0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", obs()); end
        @(posedge clk); #2;
        vectors++;
        if (run !== 1'b0) begin errors++; $display("FAIL reset_run_held: got %b expected 0", run); end
    endtask

    task automatic test_fetch_rtype();
        load_begin();
        prog_mem[0] = enc(5'b00011, 4'd1, 4'd2, 4'd3, 19'd0);
        prog_rf[2] = 32'd5; prog_rf[3] = 32'd7;
        release_clr();
        @(negedge clk); vectors++;
        if (obs() !== xp(MARIN | ZIN, PCO, 5'd14, 9'd0, 1'b1)) begin errors++; $display("FAIL fetch_t0: got %h expected %h", obs(), xp(MARIN | ZIN, PCO, 5'd14, 9'd0, 1'b1)); end
        @(negedge clk); vectors++;
        if (obs() !== xp(PCIN | MDRIN, ZLO, 5'd0, F_MDRD | F_RRD, 1'b1)) begin errors++; $display("FAIL fetch_t1: got %h expected %h", obs(), xp(PCIN | MDRIN, ZLO, 5'd0, F_MDRD | F_RRD, 1'b1)); end
        @(negedge clk); vectors++;
        if (obs() !== xp(IRIN, MDRO, 5'd0, 9'd0, 1'b1)) begin errors++; $display("FAIL fetch_t2: got %h expected %h", obs(), xp(IRIN, MDRO, 5'd0, 9'd0, 1'b1)); end
        @(negedge clk); vectors++;
        if (obs() !== xp(YIN, 32'd0, 5'd0, F_GRB | F_ROUT, 1'b1)) begin errors++; $display("FAIL add_t3: got %h expected %h", obs(), xp(YIN, 32'd0, 5'd0, F_GRB | F_ROUT, 1'b1)); end
        @(negedge clk); vectors++;
        if (obs() !== xp(ZIN, 32'd0, 5'd1, F_GRC | F_ROUT, 1'b1)) begin errors++; $display("FAIL add_t4: got %h expected %h", obs(), xp(ZIN, 32'd0, 5'd1, F_GRC | F_ROUT, 1'b1)); end
        @(negedge clk); vectors++;
        if (obs() !== xp(32'd0, ZLO, 5'd0, F_GRA | F_RIN, 1'b1)) begin errors++; $display("FAIL add_t5: got %h expected %h", obs(), xp(32'd0, ZLO, 5'd0, F_GRA | F_RIN, 1'b1)); end
        @(negedge clk); vectors++;
        if (obs() !== xp(MARIN | ZIN, PCO, 5'd14, 9'd0, 1'b1)) begin errors++; $display("FAIL add_next_t0_6cyc: got %h expected %h", obs(), xp(MARIN | ZIN, PCO, 5'd14, 9'd0, 1'b1)); end
        vectors++;
        if (rf[1] !== 32'd12) begin errors++; $display("FAIL add_result_r1: got %h expected %h", rf[1], 32'd12); end
    endtask

    task automatic test_branch(input logic [31:0] instr, input logic taken);
        load_begin();
        prog_mem[0] = instr;
        release_clr();
        repeat (4) @(negedge clk);
        vectors++;
        if (obs() !== xp(CONIN, 32'd0, 5'd0, F_GRA | F_ROUT, 1'b1)) begin errors++; $display("FAIL br_t3 taken=%0b: got %h expected %h", taken, obs(), xp(CONIN, 32'd0, 5'd0, F_GRA | F_ROUT, 1'b1)); end
        @(negedge clk); vectors++;
        if (obs() !== xp(YIN, PCO, 5'd0, 9'd0, 1'b1)) begin errors++; $display("FAIL br_t4 taken=%0b: got %h expected %h", taken, obs(), xp(YIN, PCO, 5'd0, 9'd0, 1'b1)); end
        @(negedge clk); vectors++;
        if (obs() !== xp(ZIN, COUT, 5'd1, 9'd0, 1'b1)) begin errors++; $display("FAIL br_t5 taken=%0b: got %h expected %h", taken, obs(), xp(ZIN, COUT, 5'd1, 9'd0, 1'b1)); end
        @(negedge clk); vectors++;
        if (obs() !== xp(taken ? PCIN : 32'd0, ZLO, 5'd0, 9'd0, 1'b1)) begin errors++; $display("FAIL br_t6 taken=%0b: got %h expected %h", taken, obs(), xp(taken ? PCIN : 32'd0, ZLO, 5'd0, 9'd0, 1'b1)); end
        @(negedge clk); vectors++;
        if (obs() !== xp(MARIN | ZIN, PCO, 5'd14, 9'd0, 1'b1)) begin errors++; $display("FAIL br_next_t0_7cyc taken=%0b: got %h expected %h", taken, obs(), xp(MARIN | ZIN, PCO, 5'd14, 9'd0, 1'b1)); end
        vectors++;
        if (pc !== (taken ? 32'd26 : 32'd1)) begin errors++; $display("FAIL br_pc taken=%0b: got %0d expected %0d", taken, pc, taken ? 26 : 1); end
    endtask

    task automatic test_load_store();
        logic [78:0] want;
        load_begin();
        prog_mem[0] = enc(5'b00000, 4'd1, 4'd2, 4'd0, 19'h10);
        prog_mem[1] = enc(5'b00010, 4'd1, 4'd0, 4'd0, 19'h20);
        prog_mem[9'h14] = 32'h0000_ABCD;
        prog_rf[2] = 32'd4;
        release_clr();
        for (int idx = 0; idx < 16; idx++) begin
            @(negedge clk);
            vectors++;
            if (WriteRAM !== (idx == 15)) begin errors++; $display("FAIL ldst_writeram step %0d: got %b expected %b", idx, WriteRAM, idx == 15); end
            vectors++;
            if (MD_Read !== (idx == 1 || idx == 6 || idx == 9)) begin errors++; $display("FAIL ldst_md_read step %0d: got %b", idx, MD_Read); end
            want = '0;
            case (idx)
                3:  want = xp(YIN, 32'd0, 5'd0, F_GRB | F_BA, 1'b1);
                4:  want = xp(ZIN, COUT, 5'd1, 9'd0, 1'b1);
                5:  want = xp(MARIN, ZLO, 5'd0, 9'd0, 1'b1);
                6:  want = xp(MDRIN, 32'd0, 5'd0, F_MDRD | F_RRD, 1'b1);
                7:  want = xp(32'd0, MDRO, 5'd0, F_GRA | F_RIN, 1'b1);
                14: want = xp(MDRIN, 32'd0, 5'd0, F_GRA | F_ROUT, 1'b1);
                15: want = xp(32'd0, 32'd0, 5'd0, F_WR, 1'b1);
                default: ;
            endcase
            if (want != 79'd0) begin
                vectors++;
                if (obs() !== want) begin errors++; $display("FAIL ldst_strobes step %0d: got %h expected %h", idx, obs(), want); end
            end
        end
        @(negedge clk);
        vectors++;
        if (rf[1] !== 32'h0000_ABCD) begin errors++; $display("FAIL ld_result_r1: got %h expected 0000abcd", rf[1]); end
        vectors++;
        if (mem[9'h20] !== 32'h0000_ABCD) begin errors++; $display("FAIL st_result_mem20: got %h expected 0000abcd", mem[9'h20]); end
    endtask

    task automatic test_imm_jr_nop();
        load_begin();
        prog_mem[0]  = enc(5'b01011, 4'd4, 4'd2, 4'd0, 19'h7FFFD);
        prog_mem[1]  = enc(5'b10100, 4'd5, 4'd0, 4'd0, 19'd0);
        prog_mem[9]  = 32'hD000_0000;
        prog_mem[10] = 32'hF800_0000;
        prog_rf[2] = 32'd10; prog_rf[5] = 32'd9;
        release_clr();
        repeat (5) @(negedge clk);
        vectors++;
        if (obs() !== xp(ZIN, COUT, 5'd1, 9'd0, 1'b1)) begin errors++; $display("FAIL addi_t4: got %h expected %h", obs(), xp(ZIN, COUT, 5'd1, 9'd0, 1'b1)); end
        repeat (2) @(negedge clk);
        vectors++;
        if (rf[4] !== 32'd7) begin errors++; $display("FAIL addi_result_r4: got %h expected 7", rf[4]); end
        repeat (3) @(negedge clk);
        vectors++;
        if (obs() !== xp(PCIN, 32'd0, 5'd0, F_GRA | F_ROUT, 1'b1)) begin errors++; $display("FAIL jr_t3: got %h expected %h", obs(), xp(PCIN, 32'd0, 5'd0, F_GRA | F_ROUT, 1'b1)); end
        @(negedge clk); vectors++;
        if (obs() !== xp(MARIN | ZIN, PCO, 5'd14, 9'd0, 1'b1)) begin errors++; $display("FAIL jr_next_t0_4cyc: got %h", obs()); end
        vectors++;
        if (pc !== 32'd9) begin errors++; $display("FAIL jr_pc: got %0d expected 9", pc); end
        repeat (3) @(negedge clk);
        vectors++;
        if (obs() !== xp(32'd0, 32'd0, 5'd0, 9'd0, 1'b1)) begin errors++; $display("FAIL nop_t3: got %h expected %h", obs(), xp(32'd0, 32'd0, 5'd0, 9'd0, 1'b1)); end
        @(negedge clk); vectors++;
        if (obs() !== xp(MARIN | ZIN, PCO, 5'd14, 9'd0, 1'b1)) begin errors++; $display("FAIL nop_next_t0_4cyc: got %h", obs()); end
        repeat (3) @(negedge clk);
        vectors++;
        if (obs() !== xp(32'd0, 32'd0, 5'd0, 9'd0, 1'b1)) begin errors++; $display("FAIL illegal_as_nop_t3: got %h", obs()); end
        @(negedge clk); vectors++;
        if (obs() !== xp(MARIN | ZIN, PCO, 5'd14, 9'd0, 1'b1)) begin errors++; $display("FAIL illegal_next_t0: got %h", obs()); end
    endtask

    task automatic test_halt_reset();
        load_begin();
        prog_mem[0] = 32'hD800_0000;
        release_clr();
        repeat (4) @(negedge clk);
        vectors++;
        if (obs() !== xp(32'd0, 32'd0, 5'd0, 9'd0, 1'b1)) begin errors++; $display("FAIL halt_t3: got %h expected %h", obs(), xp(32'd0, 32'd0, 5'd0, 9'd0, 1'b1)); end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            vectors++;
            if (obs() !== 79'd0) begin errors++; $display("FAIL halted_outputs cycle %0d: got %h expected 0", k, obs()); end
        end
        load_begin();
        prog_mem[0] = enc(5'b00011, 4'd1, 4'd2, 4'd3, 19'd0);
        release_clr();
        repeat (5) @(negedge clk);
        vectors++;
        if (obs() !== xp(ZIN, 32'd0, 5'd1, F_GRC | F_ROUT, 1'b1)) begin errors++; $display("FAIL pre_abort_t4: got %h", obs()); end
        #2 clr = 1'b1;
        #1;
        vectors++;
        if (obs() !== 79'd0) begin errors++; $display("FAIL async_clr_outputs: got %h expected 0", obs()); end
        @(negedge clk);
        clr = 1'b0;
        #1;
        vectors++;
        if (obs() !== 79'd0) begin errors++; $display("FAIL reset_before_edge: got %h expected 0", obs()); end
        @(negedge clk); vectors++;
        if (obs() !== xp(MARIN | ZIN, PCO, 5'd14, 9'd0, 1'b1)) begin errors++; $display("FAIL first_t0_after_clr: got %h", obs()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fetch_rtype();
        test_branch(32'h9B00_0019, 1'b1);
        test_branch(32'h9B08_0019, 1'b0);
        test_load_store();
        test_imm_jr_nop();
        test_halt_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit that sequences the existing datapath through instruction fetch and per-opcode execute steps.
- Replaces bench-driven control vectors: drives the datapath's enable, busSelect, ALU-op and Gra/Grb/Grc/Rin/Rout/BAout/RAM strobes from the IR contents and the CON flip-flop.
- One state per clk. Moore outputs, decoded from the registered state.

Parameters:
HALT_ON_ILLEGAL, 0, 1 = undefined opcode enters HALTED; 0 = undefined opcode is treated as nop

Ports:
clk  in  1  system clock; all state changes on posedge
clr  in  1  asynchronous, active-high reset
ir  in  32  instruction register contents from the datapath
CONFFOut  in  1  CON flip-flop output (branch condition)
enable  out  32  datapath register-load enables; this block drives only bits 18,19,20,21,24,25,27
busSelect  out  32  bus source one-hot; this block drives only bits 19,20,21,23
Control_Signals  out  5  ALU operation code
MD_Read  out  1  MDR input mux: 1 = memory, 0 = bus
ReadRAM  out  1  RAM read strobe
WriteRAM  out  1  RAM write strobe
Gra  out  1  select-and-encode field select: Ra
Grb  out  1  select-and-encode field select: Rb
Grc  out  1  select-and-encode field select: Rc
Rin  out  1  general-register load via select-and-encode
Rout  out  1  general-register bus drive via select-and-encode
BAout  out  1  base-address bus drive via select-and-encode
run  out  1  1 unless in RESET or HALTED

Behaviour:
- Bit map, enable: 18 Zin, 19 Yin, 20 PCin, 21 MDRin, 24 IRin, 25 MARin, 27 CONin.
- Bit map, busSelect: 19 Zlowout, 20 PCout, 21 MDRout, 23 Cout.
- All undriven enable and busSelect bits are constant 0.
- Opcode is ir[31:27].
- States: RESET, T0..T7, HALTED.
- clr high (asynchronous): state = RESET, and every output is 0, including run. The first posedge with clr low moves RESET to T0. clr asserted in any state aborts the instruction immediately; no partial strobe survives.
- Fetch:
  - T0: PCout, MARin, Control_Signals=14 (INCPC), Zin
  - T1: Zlowout, PCin, ReadRAM, MD_Read, MDRin
  - T2: MDRout, IRin
  - T2 always moves to T3. The decode in T3 uses the new ir.
- Execute. "→T0" means the next state is T0.
  - add/sub/and/or: T3 Grb Rout Yin; T4 Grc Rout ALUop Zin; T5 Zlowout Gra Rin →T0
  - addi/andi/ori: T3 Grb Rout Yin; T4 Cout ALUop Zin; T5 Zlowout Gra Rin →T0
  - ldi: T3 Grb BAout Yin; T4 Cout ADD Zin; T5 Zlowout Gra Rin →T0
  - ld: T3 Grb BAout Yin; T4 Cout ADD Zin; T5 Zlowout MARin; T6 ReadRAM MD_Read MDRin; T7 MDRout Gra Rin →T0
  - st: T3–T5 as ld; T6 Gra Rout MDRin (MD_Read=0); T7 WriteRAM →T0
  - br: T3 Gra Rout CONin; T4 PCout Yin; T5 Cout ADD Zin; T6 Zlowout, with PCin = CONFFOut sampled in T6 →T0
  - jr: T3 Gra Rout PCin →T0
  - nop: T3 with no strobes →T0
  - halt: T3 →HALTED. HALTED holds all outputs at 0 and run=0 until clr.
- Branches never stall: a not-taken branch still spends T3–T6.
- Cycles per instruction: R/imm/ldi 6, ld/st 8, br 7, jr/nop 4.
- MD_Read is the MDR mux select. It is 1 only in T1 and in ld T6.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode constants: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 01001, or 01010, addi 01011, andi 01100, ori 01101, br 10011, jr 10100, nop 11010, halt 11011
  - ALU codes: NONE 0, ADD 1, SUB 2, AND 3, OR 4, INCPC 14
  - enable and busSelect bit indices
  - state encoding
- One sub-module, ctrl_decode: combinational opcode → instruction class plus ALU code.
- The FSM and output decode stay in control_sequencer.

Test Plan:
- Fetch after reset:
  - Stimulus: clr pulse, RAM[0]=add R1,R2,R3.
  - Required: T0 drives busSelect[20], enable[25], enable[18] and Control_Signals=14. T1 drives busSelect[19], enable[20], enable[21], ReadRAM and MD_Read. T2 drives busSelect[21] and enable[24].
- R-type:
  - Stimulus: ir=add R1,R2,R3, with R2=5, R3=7.
  - Required: T3 Grb+Rout+Yin, T4 Grc+Rout+Control_Signals=1+Zin, T5 Gra+Rin; R1=12. Next T0 falls 6 cycles after the previous T0.
- Branch taken:
  - Stimulus: ir=9B000019 (brzr R6,25), with R6=0 and PC=1 after fetch.
  - Required: enable[27] in T3. enable[20] asserted in T6, PC=26.
- Branch not taken:
  - Stimulus: ir=9B080019 (brnz R6,25), with R6=0.
  - Required: enable[20]=0 in T6, PC=1.
- Load/store:
  - Stimulus: ld R1,0x10(R2) with R2=4, RAM[0x14]=0xABCD. Then st R1,0x20(R0).
  - Required: R1=0xABCD. WriteRAM asserted in T7 only. RAM[0x20]=0xABCD.
- Halt and reset:
  - Stimulus: halt, then 10 clks, then clr high mid-cycle during a T4.
  - Required: run=0 and all outputs 0 while HALTED. On clr, outputs clear immediately (asynchronously), and T0 is entered on the first posedge after clr falls.
